// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the iterative RV32M multiply/divide unit.
interface muldiv_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, funct3, rs1Data, rs2Data,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, rs1Data, rs2Data,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide on
// sign-stripped magnitudes, one bit per cycle, with a single-cycle path for divide corner cases.
module muldiv_unit (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        a_neg_q, a_neg_d;
    logic        b_neg_q, b_neg_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        a_signed, b_signed;
    logic        a_neg_in, b_neg_in;
    logic [31:0] mag_a, mag_b;
    logic        div_by_zero, div_overflow;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift, div_trial;
    logic        div_ok;
    logic [31:0] div_rem_next, div_quo_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, fixed_result;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg_in     = a_signed & bus.rs1Data[31];
    assign b_neg_in     = b_signed & bus.rs2Data[31];
    assign mag_a        = a_neg_in ? (32'd0 - bus.rs1Data) : bus.rs1Data;
    assign mag_b        = b_neg_in ? (32'd0 - bus.rs2Data) : bus.rs2Data;
    assign div_by_zero  = bus.funct3[2] & (bus.rs2Data == 32'd0);
    assign div_overflow = bus.funct3[2] & ~bus.funct3[0] &
                          (bus.rs1Data == 32'h8000_0000) & (bus.rs2Data == 32'hFFFF_FFFF);

    // Multiply: acc = {partial product high, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide: acc[31:0] shifts the dividend out at the top while quotient bits enter at the bottom.
    assign div_shift    = {rem_q, acc_q[31]};
    assign div_trial    = div_shift - {1'b0, opnd_q};
    assign div_ok       = ~div_trial[32];
    assign div_rem_next = div_ok ? div_trial[31:0] : div_shift[31:0];
    assign div_quo_next = {acc_q[30:0], div_ok};

    assign prod_fix = (a_neg_q ^ b_neg_q) ? (64'd0 - mul_next) : mul_next;
    assign quo_fix  = (a_neg_q ^ b_neg_q) ? (32'd0 - div_quo_next) : div_quo_next;
    assign rem_fix  = a_neg_q ? (32'd0 - div_rem_next) : div_rem_next;

    always_comb begin
        case (op_q)
            3'b000:         fixed_result = prod_fix[31:0];
            3'b100, 3'b101: fixed_result = quo_fix;
            3'b110, 3'b111: fixed_result = rem_fix;
            default:        fixed_result = prod_fix[63:32];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    op_d    = bus.funct3;
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                    cnt_d   = 5'd0;
                    rem_d   = 32'd0;
                    busy_d  = 1'b1;
                    if (bus.funct3[2]) begin
                        opnd_d = mag_b;
                        acc_d  = {32'd0, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {32'd0, mag_b};
                    end
                    if (div_by_zero) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = bus.funct3[1] ? bus.rs1Data : 32'hFFFF_FFFF;
                    end else if (div_overflow) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (op_q[2]) begin
                    acc_d = {32'd0, div_quo_next};
                    rem_d = div_rem_next;
                end else begin
                    acc_d = mul_next;
                end
                // The 32nd iteration is folded straight into the sign-fixed result.
                if (cnt_q == 5'd31) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = fixed_result;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            opnd_q   <= 32'd0;
            acc_q    <= 64'd0;
            rem_q    <= 32'd0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, reset abort, back-to-back
// handshake and randomized operations against a plain-arithmetic RV32M reference.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    muldiv_if bus ();

    muldiv_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "simulation timeout");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f >= 3'd4 && b == 32'd0) return 0;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // Waits for done after acceptance; idx counts edges after the accepting edge.
    task automatic wait_done(input bit scramble, output int idx);
        int gaps;
        idx  = 0;
        gaps = 0;
        while (!bus.done && idx < 40) begin
            if (scramble) begin
                bus.start   = 1'($urandom_range(0, 1));
                bus.funct3  = 3'($urandom);
                bus.rs1Data = $urandom;
                bus.rs2Data = $urandom;
            end
            @(posedge clk); #1;
            idx++;
            if (!bus.busy) gaps++;
        end
        bus.start = 1'b0;
        check_value("busy_gap", gaps, 0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit scramble);
        logic [31:0] exp;
        int          exp_lat;
        int          idx;
        exp     = ref_result(f, a, b);
        exp_lat = ref_latency(f, a, b);
        bus.start   = 1'b1;
        bus.funct3  = f;
        bus.rs1Data = a;
        bus.rs2Data = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_value({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(scramble, idx);
        check_value({tag, "_res"}, bus.result, exp);
        check_value({tag, "_lat"}, idx, exp_lat);
        $display("%s f3=%0d a=%08h b=%08h result=%08h expect=%08h lat=%0d", tag, f, a, b,
                 bus.result, exp, idx);
        @(posedge clk); #1;
        check_value({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    logic [2:0]  dir_f [13] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd7, 3'd5, 3'd6,
                                3'd4, 3'd6, 3'd0, 3'd5};
    logic [31:0] dir_a [13] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'h1234, 32'h1234,
                                32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] dir_b [13] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd2, 32'd2, 32'd7, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};

    initial begin
        int idx;
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.funct3  = 3'd0;
        bus.rs1Data = 32'd0;
        bus.rs2Data = 32'd0;
        #2;
        check_value("reset_state", {bus.result[31:2], bus.busy, bus.done}, 32'd0);
        check_value("reset_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run_op("dir", dir_f[i], dir_a[i], dir_b[i], 1'b0);

        // Abort at counter 10; previous directed result is nonzero so the clear is visible.
        bus.start   = 1'b1;
        bus.funct3  = 3'd0;
        bus.rs1Data = 32'd1000;
        bus.rs2Data = 32'd1000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_value("rst_mid_flags", {30'd0, bus.busy, bus.done}, 32'd0);
        check_value("rst_mid_res", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 3'd0, 32'd3, 32'd5, 1'b0);

        // start held high across two operations
        bus.start   = 1'b1;
        bus.funct3  = 3'd0;
        bus.rs1Data = 32'd2;
        bus.rs2Data = 32'd3;
        @(posedge clk); #1;
        wait_done(1'b0, idx);
        check_value("b2b_res1", bus.result, 32'd6);
        check_value("b2b_lat1", idx, 32);
        bus.start   = 1'b1;
        bus.funct3  = 3'd5;
        bus.rs1Data = 32'd9;
        bus.rs2Data = 32'd3;
        @(posedge clk); #1;
        check_value("b2b_idle", {30'd0, bus.busy, bus.done}, 32'd0);
        @(posedge clk); #1;
        check_value("b2b_accept", 32'(bus.busy), 32'd1);
        wait_done(1'b0, idx);
        check_value("b2b_res2", bus.result, 32'd3);
        check_value("b2b_lat2", idx, 32);
        $display("b2b results 6 then %0d", bus.result);
        @(posedge clk); #1;
        check_value("b2b_end", {30'd0, bus.busy, bus.done}, 32'd0);

        // Operand changes and stray start pulses during CALC
        run_op("noise", 3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        run_op("noise", 3'd6, 32'hFFFF_FF00, 32'd13, 1'b1);

        for (int i = 0; i < 150; i++) begin
            run_op("rand", 3'($urandom), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
